// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + producing ROB tag).
// Issue marks destinations in flight; in-order commits write data and release matching renames.
module reg_status_file #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned TAG_W = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               issue_valid,
    input  logic [4:0]         issue_rd,
    input  logic [TAG_W-1:0]   issue_tag,
    input  logic [4:0]         rs1_addr,
    input  logic [4:0]         rs2_addr,
    output logic [XLEN-1:0]    rs1_value,
    output logic               rs1_busy,
    output logic [TAG_W-1:0]   rs1_tag,
    output logic [XLEN-1:0]    rs2_value,
    output logic               rs2_busy,
    output logic [TAG_W-1:0]   rs2_tag,
    input  logic               commit_valid,
    input  logic [4:0]         commit_idx,
    input  logic [TAG_W-1:0]   commit_tag,
    input  logic [XLEN-1:0]    commit_data,
    input  logic               flush,
    output logic [CNT_W-1:0]   retire_count
);

    localparam int unsigned AW = 5;

    logic [XLEN-1:0]  data_q [NREG];
    logic [TAG_W-1:0] tag_q  [NREG];
    logic [NREG-1:0]  busy_q;

    logic commit_we_c;
    logic issue_we_c;
    logic commit_match_c;

    assign commit_we_c    = commit_valid && (commit_idx != '0);
    assign issue_we_c     = issue_valid && (issue_rd != '0) && !flush;
    assign commit_match_c = busy_q[commit_idx] && (tag_q[commit_idx] == commit_tag);

    // Later assignments win: flush clears everything, an issue overrides a same-reg commit release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            busy_q       <= '0;
            retire_count <= '0;
        end else begin
            if (flush) begin
                busy_q <= '0;
            end
            if (commit_we_c) begin
                data_q[commit_idx] <= commit_data;
                if (commit_match_c) begin
                    busy_q[commit_idx] <= 1'b0;
                end
            end
            if (issue_we_c) begin
                busy_q[issue_rd] <= 1'b1;
                tag_q[issue_rd]  <= issue_tag;
            end
            if (commit_valid) begin
                retire_count <= retire_count + CNT_W'(1);
            end
        end
    end

    // Combinational read ports with same-cycle commit bypass; issue never bypasses.
    logic rs1_hit_c;
    logic rs2_hit_c;

    assign rs1_hit_c = commit_valid && (commit_idx == rs1_addr) && (rs1_addr != AW'(0));
    assign rs2_hit_c = commit_valid && (commit_idx == rs2_addr) && (rs2_addr != AW'(0));

    assign rs1_value = rs1_hit_c ? commit_data : data_q[rs1_addr];
    assign rs1_busy  = busy_q[rs1_addr] && !(rs1_hit_c && (tag_q[rs1_addr] == commit_tag));
    assign rs1_tag   = tag_q[rs1_addr];

    assign rs2_value = rs2_hit_c ? commit_data : data_q[rs2_addr];
    assign rs2_busy  = busy_q[rs2_addr] && !(rs2_hit_c && (tag_q[rs2_addr] == commit_tag));
    assign rs2_tag   = tag_q[rs2_addr];

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file: rename tracking, commit bypass, flush, x0 and counter wrap.
module tb_reg_status_file;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_tag;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_value;
    logic        rs1_busy;
    logic [2:0]  rs1_tag;
    logic [31:0] rs2_value;
    logic        rs2_busy;
    logic [2:0]  rs2_tag;
    logic        commit_valid;
    logic [4:0]  commit_idx;
    logic [2:0]  commit_tag;
    logic [31:0] commit_data;
    logic        flush;
    logic [15:0] retire_count;

    int checks = 0;
    int errors = 0;

    reg_status_file dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_tag    (issue_tag),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_value    (rs1_value),
        .rs1_busy     (rs1_busy),
        .rs1_tag      (rs1_tag),
        .rs2_value    (rs2_value),
        .rs2_busy     (rs2_busy),
        .rs2_tag      (rs2_tag),
        .commit_valid (commit_valid),
        .commit_idx   (commit_idx),
        .commit_tag   (commit_tag),
        .commit_data  (commit_data),
        .flush        (flush),
        .retire_count (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen a few units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        issue_rd     = '0;
        issue_tag    = '0;
        commit_valid = 1'b0;
        commit_idx   = '0;
        commit_tag   = '0;
        commit_data  = '0;
        flush        = 1'b0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [2:0] tag);
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_tag   = tag;
    endtask

    task automatic do_commit(input logic [4:0] idx, input logic [2:0] tag, input logic [31:0] data);
        commit_valid = 1'b1;
        commit_idx   = idx;
        commit_tag   = tag;
        commit_data  = data;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        rs1_addr = 5'd5;
        rs2_addr = 5'd0;
        #1;
        // Reset state
        chk("rst_rs1_value", rs1_value, 32'h0);
        chk("rst_rs1_busy",  32'(rs1_busy), 32'h0);
        chk("rst_rs1_tag",   32'(rs1_tag), 32'h0);
        chk("rst_rs2_value", rs2_value, 32'h0);
        chk("rst_rs2_busy",  32'(rs2_busy), 32'h0);
        chk("rst_count",     32'(retire_count), 32'h0);
        #11 rst_n = 1'b1;
        tick();

        // Issue then commit with matching tag, including same-cycle bypass
        do_issue(5'd3, 3'd2);
        tick();
        idle();
        rs1_addr = 5'd3;
        #1;
        chk("t2_busy_after_issue", 32'(rs1_busy), 32'h1);
        chk("t2_tag_after_issue",  32'(rs1_tag), 32'h2);
        do_commit(5'd3, 3'd2, 32'hDEADBEEF);
        #1;
        chk("t2_bypass_value", rs1_value, 32'hDEADBEEF);
        chk("t2_bypass_busy",  32'(rs1_busy), 32'h0);
        tick();
        idle();
        #1;
        chk("t2_post_value", rs1_value, 32'hDEADBEEF);
        chk("t2_post_busy",  32'(rs1_busy), 32'h0);
        chk("t2_count",      32'(retire_count), 32'h1);

        // Stale-tag commit writes data but keeps the newer rename
        do_issue(5'd4, 3'd1);
        tick();
        do_issue(5'd4, 3'd5);
        tick();
        idle();
        rs1_addr = 5'd4;
        do_commit(5'd4, 3'd1, 32'd7);
        #1;
        chk("t3_stale_bypass_value", rs1_value, 32'd7);
        chk("t3_stale_bypass_busy",  32'(rs1_busy), 32'h1);
        tick();
        idle();
        #1;
        chk("t3_stale_value", rs1_value, 32'd7);
        chk("t3_stale_busy",  32'(rs1_busy), 32'h1);
        chk("t3_stale_tag",   32'(rs1_tag), 32'h5);
        do_commit(5'd4, 3'd5, 32'd9);
        tick();
        idle();
        #1;
        chk("t3_final_value", rs1_value, 32'd9);
        chk("t3_final_busy",  32'(rs1_busy), 32'h0);

        // Simultaneous issue and commit to the same register
        rs2_addr = 5'd6;
        do_issue(5'd6, 3'd0);
        do_commit(5'd6, 3'd3, 32'h11);
        #1;
        chk("t4_same_cycle_value", rs2_value, 32'h11);
        chk("t4_same_cycle_busy",  32'(rs2_busy), 32'h0);
        tick();
        idle();
        #1;
        chk("t4_value", rs2_value, 32'h11);
        chk("t4_busy",  32'(rs2_busy), 32'h1);
        chk("t4_tag",   32'(rs2_tag), 32'h0);
        chk("t4_count", 32'(retire_count), 32'h4);

        // Flush with concurrent commit; concurrent issue ignored
        do_issue(5'd1, 3'd0);
        tick();
        do_issue(5'd2, 3'd1);
        tick();
        do_issue(5'd7, 3'd2);
        tick();
        idle();
        rs1_addr = 5'd1;
        rs2_addr = 5'd7;
        #1;
        chk("t5_r1_busy_pre", 32'(rs1_busy), 32'h1);
        chk("t5_r7_busy_pre", 32'(rs2_busy), 32'h1);
        chk("t5_r7_tag_pre",  32'(rs2_tag), 32'h2);
        flush = 1'b1;
        do_issue(5'd2, 3'd3);
        do_commit(5'd1, 3'd0, 32'd5);
        tick();
        idle();
        #1;
        chk("t5_r1_value", rs1_value, 32'd5);
        chk("t5_r1_busy",  32'(rs1_busy), 32'h0);
        chk("t5_r7_busy",  32'(rs2_busy), 32'h0);
        rs2_addr = 5'd2;
        #1;
        chk("t5_r2_busy", 32'(rs2_busy), 32'h0);
        chk("t5_r2_tag",  32'(rs2_tag), 32'h1);

        // Writes and issues to x0 have no effect
        rs1_addr = 5'd0;
        do_commit(5'd0, 3'd4, 32'hFFFFFFFF);
        do_issue(5'd0, 3'd6);
        #1;
        chk("t5_x0_bypass_value", rs1_value, 32'h0);
        tick();
        idle();
        #1;
        chk("t5_x0_value", rs1_value, 32'h0);
        chk("t5_x0_busy",  32'(rs1_busy), 32'h0);
        chk("t5_x0_tag",   32'(rs1_tag), 32'h0);
        chk("t5_count",    32'(retire_count), 32'h6);

        // Mid-cycle async reset clears the counter, then count to the wrap point
        rst_n = 1'b0;
        #1;
        chk("t6_async_rst_count", 32'(retire_count), 32'h0);
        rst_n = 1'b1;
        do_commit(5'd0, 3'd0, 32'h0);
        repeat (16'hFFFF) tick();
        idle();
        #1;
        chk("t6_count_max", 32'(retire_count), 32'hFFFF);
        do_commit(5'd0, 3'd0, 32'h0);
        tick();
        idle();
        #1;
        chk("t6_count_wrap", 32'(retire_count), 32'h0);

        // Build up state, then reset between edges
        do_issue(5'd9, 3'd4);
        do_commit(5'd3, 3'd0, 32'h55);
        tick();
        idle();
        rs1_addr = 5'd9;
        rs2_addr = 5'd3;
        #1;
        chk("t6_pre_rst_busy",  32'(rs1_busy), 32'h1);
        chk("t6_pre_rst_value", rs2_value, 32'h55);
        chk("t6_pre_rst_count", 32'(retire_count), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_count", 32'(retire_count), 32'h0);
        chk("t6_rst_busy",  32'(rs1_busy), 32'h0);
        chk("t6_rst_tag",   32'(rs1_tag), 32'h0);
        chk("t6_rst_value", rs2_value, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
